// File: rtl/data_cache_if.sv
// Pipeline request/response and backing-memory bus of the L1 data cache.
// slave is the cache side; master is the pipeline plus memory side.
interface data_cache_if #(
  parameter int unsigned ADDR_WIDTH = 17
);
  logic                  req_read;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [2:0]            size_src;
  logic [31:0]           rdata;
  logic                  stall;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_be;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  modport master (
    output req_read, req_write, addr, wdata, size_src, mem_ack, mem_rdata,
    input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  req_read, req_write, addr, wdata, size_src, mem_ack, mem_rdata,
    output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache in front of a
// multi-cycle backing memory. Read hits are zero-latency; misses and stores stall.
module data_cache #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned LINES       = 64,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input logic         clk,
  input logic         rst,
  data_cache_if.slave bus
);

  localparam int unsigned WB = $clog2(BLOCK_WORDS);
  localparam int unsigned IB = $clog2(LINES);
  localparam int unsigned TB = ADDR_WIDTH - 2 - WB - IB;

  typedef enum logic [1:0] {StIdle, StRefill, StWrite} state_e;

  state_e                state_q, state_d;
  logic [WB-1:0]         cnt_q, cnt_d;

  logic [LINES-1:0]      valid_q;
  logic [TB-1:0]         tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES][BLOCK_WORDS];

  // Request captured while idle so the memory bus stays stable during REFILL/WRITE.
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [31:0]           r_wdata_q;
  logic [1:0]            r_size_q;

  logic [TB-1:0]         tag, r_tag;
  logic [IB-1:0]         idx, r_idx;
  logic [WB-1:0]         word, r_word;
  logic                  hit, w_hit;
  logic                  refill_ack, refill_last, write_ack;
  logic [3:0]            wr_be;
  logic [31:0]           wr_data;
  logic [DATA_WIDTH-1:0] word_sel;
  logic [31:0]           shifted_b, shifted_h;

  assign tag    = bus.addr[ADDR_WIDTH-1 -: TB];
  assign idx    = bus.addr[2+WB +: IB];
  assign word   = bus.addr[2 +: WB];
  assign r_tag  = r_addr_q[ADDR_WIDTH-1 -: TB];
  assign r_idx  = r_addr_q[2+WB +: IB];
  assign r_word = r_addr_q[2 +: WB];

  assign hit   = valid_q[idx] && (tag_q[idx] == tag);
  assign w_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

  assign refill_ack  = (state_q == StRefill) && bus.mem_ack;
  assign refill_last = refill_ack && (cnt_q == WB'(BLOCK_WORDS - 1));
  assign write_ack   = (state_q == StWrite) && bus.mem_ack;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_write) begin
          state_d = StWrite;
        end else if (bus.req_read && !hit) begin
          state_d = StRefill;
          cnt_d   = '0;
        end
      end
      StRefill: begin
        if (bus.mem_ack) begin
          cnt_d = cnt_q + WB'(1);
          if (refill_last) state_d = StIdle;
        end
      end
      StWrite: begin
        if (bus.mem_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Store lane steering from the captured request
  always_comb begin
    unique case (r_size_q)
      2'b00: begin
        wr_be   = 4'b0001 << r_addr_q[1:0];
        wr_data = {4{r_wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be   = r_addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{r_wdata_q[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = r_wdata_q;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.stall     = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    unique case (state_q)
      StIdle: begin
        // Gated by rst so a held request cannot stall the pipeline during reset.
        bus.stall = !rst && (bus.req_write || (bus.req_read && !hit));
      end
      StRefill: begin
        bus.stall    = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = {r_addr_q[ADDR_WIDTH-1:2+WB], cnt_q, 2'b00};
      end
      StWrite: begin
        bus.stall     = !bus.mem_ack;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {r_addr_q[ADDR_WIDTH-1:2], 2'b00};
        bus.mem_wdata = wr_data;
        bus.mem_be    = wr_be;
      end
      default: ;
    endcase
  end

  // Load extraction
  always_comb begin
    word_sel  = data_q[idx][word];
    shifted_b = word_sel >> {bus.addr[1:0], 3'b000};
    shifted_h = word_sel >> {bus.addr[1], 4'b0000};
    unique case (bus.size_src[1:0])
      2'b00:   bus.rdata = bus.size_src[2] ? {24'b0, shifted_b[7:0]}
                                           : {{24{shifted_b[7]}}, shifted_b[7:0]};
      2'b01:   bus.rdata = bus.size_src[2] ? {16'b0, shifted_h[15:0]}
                                           : {{16{shifted_h[15]}}, shifted_h[15:0]};
      default: bus.rdata = word_sel;
    endcase
    if (rst) bus.rdata = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      r_addr_q  <= '0;
      r_wdata_q <= '0;
      r_size_q  <= '0;
    end else begin
      if (state_q == StIdle) begin
        r_addr_q  <= bus.addr;
        r_wdata_q <= bus.wdata;
        r_size_q  <= bus.size_src[1:0];
      end
      // Invalidate on refill start so a partially overwritten line never hits.
      if (state_q == StIdle && state_d == StRefill) valid_q[idx] <= 1'b0;
      if (refill_last) valid_q[r_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (refill_ack) begin
      data_q[r_idx][cnt_q] <= bus.mem_rdata;
      if (refill_last) tag_q[r_idx] <= r_tag;
    end
    if (write_ack && w_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) data_q[r_idx][r_word][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule
